// File: rtl/alu_accumulator_seq_if.sv
// Operand/result bus between the accumulator sequencer and the combinational ALU.
interface alu_accumulator_seq_if #(parameter int N = 4);
  logic [N-1:0] alu_x;
  logic [N-1:0] alu_y;
  logic [2:0]   alu_op;
  logic [N-1:0] alu_f;
  logic [3:0]   alu_flags;

  modport master (output alu_x, alu_y, alu_op, input alu_f, alu_flags);
  modport slave  (input alu_x, alu_y, alu_op, output alu_f, alu_flags);
endinterface

// File: rtl/alu_accumulator_seq.sv
// Press-to-execute sequencer: button sync/edge detect, accumulator, and a
// one-shot IDLE->ISSUE->HOLD cycle that captures the external ALU result.
module alu_accumulator_seq_btn (
  input  logic clk,
  input  logic rst,
  input  logic fill,
  input  logic raw,
  output logic pulse
);
  logic s1, s2, hist, armed;

  // armed stays low until the button is seen released after reset, so a
  // button held through reset never fires on its own.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      hist  <= 1'b0;
      armed <= 1'b0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      hist  <= s2;
      armed <= armed | (fill & ~s1);
    end
  end

  assign pulse = s2 & ~hist & armed;
endmodule

module alu_accumulator_seq #(
  parameter int N     = 4,
  parameter int CNT_W = 8
) (
  input  logic                 CLOCK,
  input  logic                 RESET,
  input  logic                 btn_clear,
  input  logic                 btn_load,
  input  logic                 btn_exec,
  input  logic [N-1:0]         din,
  input  logic [2:0]           op,
  alu_accumulator_seq_if.master alu,
  output logic [N-1:0]         acc,
  output logic [3:0]           flags_q,
  output logic                 sticky_v,
  output logic [CNT_W-1:0]     op_count,
  output logic                 busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

  state_t       state, state_nxt;
  logic         fill;
  logic [2:0]   pulse;
  logic         p_clr, p_ld, p_ex;
  logic         do_ld, do_ex, do_cap;
  logic [N-1:0] y_reg;
  logic [2:0]   op_reg;

  alu_accumulator_seq_btn u_btn [2:0] (
    .clk   (CLOCK),
    .rst   (RESET),
    .fill  (fill),
    .raw   ({btn_clear, btn_load, btn_exec}),
    .pulse (pulse)
  );

  assign p_clr = pulse[2];
  assign p_ld  = pulse[1];
  assign p_ex  = pulse[0];

  assign alu.alu_x  = acc;
  assign alu.alu_y  = y_reg;
  assign alu.alu_op = op_reg;

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    do_ld     = p_ld & ~p_clr & (state == IDLE);
    do_ex     = p_ex & ~p_clr & ~p_ld & (state == IDLE);
    do_cap    = (state == ISSUE) & ~p_clr;
    case (state)
      IDLE:    if (do_ex) state_nxt = ISSUE;
      ISSUE:   state_nxt = HOLD;
      HOLD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (p_clr) state_nxt = IDLE;
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state    <= IDLE;
      fill     <= 1'b0;
      acc      <= '0;
      flags_q  <= '0;
      sticky_v <= 1'b0;
      op_count <= '0;
      y_reg    <= '0;
      op_reg   <= '0;
    end else begin
      state <= state_nxt;
      fill  <= 1'b1;
      if (p_clr) begin
        acc      <= '0;
        flags_q  <= '0;
        sticky_v <= 1'b0;
        op_count <= '0;
      end else if (do_ld) begin
        acc <= din;
      end else if (do_cap) begin
        acc      <= alu.alu_f;
        flags_q  <= alu.alu_flags;
        sticky_v <= sticky_v | alu.alu_flags[1];
        if (op_count != {CNT_W{1'b1}}) op_count <= op_count + CNT_W'(1);
      end
      if (do_ex) begin
        y_reg  <= din;
        op_reg <= op;
      end
    end
  end
endmodule

// File: tb/tb_alu_accumulator_seq.sv
// Scoreboarded bench: a 4-bit ALU model hangs off the interface; stimulus pushes
// expected states, a monitor pops them on exec completion or on snapshot requests.
module tb_alu_accumulator_seq;
  logic       CLOCK = 1'b0;
  logic       RESET = 1'b1;
  logic       btn_clear = 1'b1, btn_load = 1'b1, btn_exec = 1'b1;
  logic [3:0] din = 4'h5;
  logic [2:0] op  = 3'b100;
  logic [3:0] acc, flags_q;
  logic       sticky_v, busy;
  logic [7:0] op_count;

  alu_accumulator_seq_if #(.N(4)) alu_if ();

  alu_accumulator_seq #(.N(4), .CNT_W(8)) dut (
    .CLOCK(CLOCK), .RESET(RESET),
    .btn_clear(btn_clear), .btn_load(btn_load), .btn_exec(btn_exec),
    .din(din), .op(op), .alu(alu_if),
    .acc(acc), .flags_q(flags_q), .sticky_v(sticky_v),
    .op_count(op_count), .busy(busy)
  );

  always #50 CLOCK = ~CLOCK;

  // ALU model: 000 add, 001 and, 010 or, 011 xor, 100 sub (carry = borrow)
  logic [3:0] ax, ay, ar;
  logic [4:0] asum;
  logic       ac, av;
  always_comb begin
    ax = alu_if.alu_x;
    ay = alu_if.alu_y;
    ar = ax; ac = 1'b0; av = 1'b0; asum = 5'd0;
    case (alu_if.alu_op)
      3'b000: begin
        asum = {1'b0, ax} + {1'b0, ay};
        ar = asum[3:0]; ac = asum[4];
        av = (ax[3] == ay[3]) && (ar[3] != ax[3]);
      end
      3'b001: ar = ax & ay;
      3'b010: ar = ax | ay;
      3'b011: ar = ax ^ ay;
      3'b100: begin
        ar = ax - ay; ac = (ax < ay);
        av = (ax[3] != ay[3]) && (ar[3] != ax[3]);
      end
      default: ar = ax;
    endcase
    alu_if.alu_f     = ar;
    alu_if.alu_flags = {ar[3], ar == 4'd0, av, ac};
  end

  // kind 0: snapshot, 1: completed exec, 2: exec aborted by clear in ISSUE
  typedef struct {
    int         kind;
    logic [3:0] acc;
    logic [3:0] flags;
    logic       sticky;
    logic [7:0] cnt;
    bit         full;
    logic [3:0] y;
    logic [2:0] op;
    int         k;
  } exp_t;

  exp_t q[$];
  int   cyc = 0, req_n = 0, ack_n = 0, rise_cyc = -1;
  int   n_cmp = 0, n_bad = 0;
  logic busy_d = 1'b0;

  always @(posedge CLOCK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, a, e, cyc);
    end
  endtask

  task automatic bad(input string nm);
    n_cmp++; n_bad++;
    $display("FAIL %s: no matching expectation (cycle %0d)", nm, cyc);
  endtask

  task automatic cmp_state(input exp_t e);
    chk("acc", 32'(acc), 32'(e.acc));
    chk("alu_x", 32'(alu_if.alu_x), 32'(e.acc));
    chk("flags_q", 32'(flags_q), 32'(e.flags));
    chk("sticky_v", 32'(sticky_v), 32'(e.sticky));
    chk("op_count", 32'(op_count), 32'(e.cnt));
  endtask

  // monitor
  always @(posedge CLOCK) begin
    exp_t e;
    #1;
    if (q.size() > 0 && q[0].kind == 1 && cyc == q[0].k + 3)
      chk("cap_acc_k3", 32'(acc), 32'(q[0].acc));
    if (busy && !busy_d) rise_cyc = cyc;
    if (!busy && busy_d) begin
      if (q.size() == 0 || q[0].kind == 0) bad("unexpected_done");
      else begin
        e = q.pop_front();
        cmp_state(e);
        chk("busy_rise_cyc", 32'(rise_cyc), 32'(e.k + 2));
        chk("busy_fall_cyc", 32'(cyc), 32'((e.kind == 1) ? e.k + 4 : e.k + 3));
      end
    end
    if (req_n != ack_n) begin
      ack_n++;
      if (q.size() == 0 || q[0].kind != 0) bad("snapshot_order");
      else begin
        e = q.pop_front();
        cmp_state(e);
        chk("busy", 32'(busy), 32'd0);
        if (e.full) begin
          chk("alu_y", 32'(alu_if.alu_y), 32'(e.y));
          chk("alu_op", 32'(alu_if.alu_op), 32'(e.op));
        end
      end
    end
    busy_d = busy;
  end

  task automatic snap(input logic [3:0] a, input logic [3:0] f, input logic s,
                      input logic [7:0] c, input bit full, input logic [3:0] y,
                      input logic [2:0] o);
    exp_t e;
    e = '{kind: 0, acc: a, flags: f, sticky: s, cnt: c, full: full, y: y, op: o, k: 0};
    q.push_back(e);
    req_n++;
    @(negedge CLOCK); @(negedge CLOCK);
  endtask

  task automatic push_exec(input int kind, input logic [3:0] a, input logic [3:0] f,
                           input logic s, input logic [7:0] c);
    exp_t e;
    e = '{kind: kind, acc: a, flags: f, sticky: s, cnt: c, full: 1'b0, y: 4'd0, op: 3'd0, k: cyc + 1};
    q.push_back(e);
  endtask

  task automatic press(input int which, input logic [3:0] d);
    @(negedge CLOCK);
    din = d;
    if (which == 0) btn_clear = 1'b1; else btn_load = 1'b1;
    @(negedge CLOCK); @(negedge CLOCK);
    btn_clear = 1'b0; btn_load = 1'b0;
    repeat (3) @(negedge CLOCK);
  endtask

  task automatic exec_op(input logic [3:0] d, input logic [2:0] o, input logic [3:0] ea,
                         input logic [3:0] ef, input logic es, input logic [7:0] ec);
    @(negedge CLOCK);
    din = d; op = o; btn_exec = 1'b1;
    push_exec(1, ea, ef, es, ec);
    @(negedge CLOCK); @(negedge CLOCK);
    btn_exec = 1'b0;
    repeat (4) @(negedge CLOCK);
  endtask

  initial begin
    // reset with every button held high
    repeat (2) @(negedge CLOCK);
    snap(4'h0, 4'h0, 1'b0, 8'd0, 1'b1, 4'h0, 3'b000);
    RESET = 1'b0;
    repeat (5) @(negedge CLOCK);
    snap(4'h0, 4'h0, 1'b0, 8'd0, 1'b1, 4'h0, 3'b000);
    btn_clear = 1'b0; btn_load = 1'b0; btn_exec = 1'b0;
    repeat (3) @(negedge CLOCK);

    press(1, 4'h5);
    snap(4'h5, 4'h0, 1'b0, 8'd0, 1'b1, 4'h0, 3'b000);
    exec_op(4'h3, 3'b000, 4'h8, 4'b1010, 1'b1, 8'd1);     // 5+3 overflows signed
    snap(4'h8, 4'b1010, 1'b1, 8'd1, 1'b1, 4'h3, 3'b000);

    press(1, 4'h3);
    exec_op(4'h3, 3'b100, 4'h0, 4'b0100, 1'b1, 8'd2);     // 3-3
    press(1, 4'hC);
    exec_op(4'hA, 3'b001, 4'h8, 4'b1000, 1'b1, 8'd3);     // C & A
    exec_op(4'hF, 3'b011, 4'h7, 4'b0000, 1'b1, 8'd4);     // 8 ^ F
    snap(4'h7, 4'b0000, 1'b1, 8'd4, 1'b1, 4'hF, 3'b011);

    // load pulse lands in HOLD and must be dropped
    @(negedge CLOCK);
    din = 4'h1; op = 3'b000; btn_exec = 1'b1;
    push_exec(1, 4'h8, 4'b1010, 1'b1, 8'd5);              // 7+1
    @(negedge CLOCK); @(negedge CLOCK);
    btn_exec = 1'b0; btn_load = 1'b1;
    @(negedge CLOCK); @(negedge CLOCK);
    btn_load = 1'b0;
    repeat (4) @(negedge CLOCK);
    snap(4'h8, 4'b1010, 1'b1, 8'd5, 1'b1, 4'h1, 3'b000);

    // clear and exec together in IDLE: clear wins, exec operands not latched
    @(negedge CLOCK);
    din = 4'h9; op = 3'b010; btn_clear = 1'b1; btn_exec = 1'b1;
    @(negedge CLOCK); @(negedge CLOCK);
    btn_clear = 1'b0; btn_exec = 1'b0;
    repeat (4) @(negedge CLOCK);
    snap(4'h0, 4'h0, 1'b0, 8'd0, 1'b1, 4'h1, 3'b000);

    // clear arriving in the ISSUE cycle suppresses the capture
    press(1, 4'h6);
    @(negedge CLOCK);
    din = 4'h2; op = 3'b000; btn_exec = 1'b1;
    push_exec(2, 4'h0, 4'h0, 1'b0, 8'd0);
    @(negedge CLOCK);
    btn_clear = 1'b1;
    @(negedge CLOCK);
    btn_exec = 1'b0;
    @(negedge CLOCK);
    btn_clear = 1'b0;
    repeat (4) @(negedge CLOCK);
    snap(4'h0, 4'h0, 1'b0, 8'd0, 1'b1, 4'h2, 3'b000);

    // counter saturation
    for (int i = 0; i < 260; i++)
      exec_op(4'h0, 3'b001, 4'h0, 4'b0100, 1'b0, (i + 1 > 255) ? 8'd255 : 8'(i + 1));
    snap(4'h0, 4'b0100, 1'b0, 8'd255, 1'b1, 4'h0, 3'b001);

    repeat (5) @(negedge CLOCK);
    if (q.size() != 0) bad("scoreboard_drain");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
